axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_MST, default 2 (legal 2..8); number of AXI4-lite read masters.
REQ-002 SHALL have parameter ADDR_W, default 32; address width.
REQ-003 SHALL have parameter DATA_W, default 32; data width.
REQ-004 SHALL have parameter TIMEOUT, default 256; cycles allowed for a read response. 0 disables the timeout.
REQ-005 SHALL have one clock and one reset: reset is synchronous and active-high. Port names clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 m_arvalid  input  NUM_MST  per-master AR valid.
REQ-009 m_araddr  input  NUM_MST*ADDR_W  per-master AR address; master i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 m_arready  output  NUM_MST  per-master AR ready.
REQ-011 m_rvalid  output  NUM_MST  per-master R valid.
REQ-012 m_rdata  output  DATA_W  shared R data; valid only for the master whose m_rvalid is high.
REQ-013 m_rresp  output  2  shared R response.
REQ-014 m_rready  input  NUM_MST  per-master R ready.
REQ-015 s_arvalid, s_araddr[ADDR_W], s_arready(in), s_rvalid(in), s_rdata[DATA_W](in), s_rresp[2](in), s_rready: the slave-side AR/R channel. Slave outputs are listed without (in); slave inputs are marked (in).
REQ-016 grant_idx  output  $clog2(NUM_MST)  index of the current or last granted master.
REQ-017 busy  output  1  high in states ADDR, DATA and ERR.

Function
REQ-018 SHALL implement the FSM states IDLE, ADDR, DATA and ERR.
REQ-019 IDLE: when any m_arvalid bit is high, the FSM SHALL register grant_idx as the first requester found searching from rr_ptr upward with modulo NUM_MST wrap, and SHALL move to ADDR. Otherwise it stays in IDLE.
REQ-020 ADDR: the block SHALL drive s_arvalid = m_arvalid[g], s_araddr = the slice for g, and m_arready[g] = s_arready. All other m_arready bits SHALL be 0. On the s_arvalid & s_arready handshake the FSM moves to DATA and clears tmo_cnt.
REQ-021 DATA: the block SHALL drive m_rvalid[g] = s_rvalid, m_rdata = s_rdata, m_rresp = s_rresp, and s_rready = m_rready[g]. On the handshake: move to IDLE, and set rr_ptr = (g+1) mod NUM_MST.
REQ-022 DATA with TIMEOUT != 0: tmo_cnt SHALL increment every cycle without s_rvalid. The counter is ceil(log2(TIMEOUT+1)) bits and never wraps. When tmo_cnt == TIMEOUT-1 and s_rvalid is 0, the FSM SHALL move to ERR.
REQ-023 ERR: the block SHALL drive m_rvalid[g]=1, m_rdata=0, m_rresp=2'b10 (SLVERR). On m_rready[g]: move to IDLE, set rr_ptr=(g+1) mod NUM_MST, and set the sticky late_pending flag.
REQ-024 s_rready SHALL be 1 in IDLE and ERR, and 0 in ADDR. A slave R beat arriving outside DATA SHALL be discarded and never forwarded. When s_rvalid & s_rready occur while late_pending is set, late_pending SHALL clear.
REQ-025 While late_pending is set, IDLE SHALL NOT grant. This prevents a stale beat from being matched to a new request.
REQ-026 Latency: m_arvalid at cycle N gives s_arvalid at cycle N+1, at the earliest. The R path is combinational pass-through in DATA, with zero added latency.
REQ-027 Only one outstanding transaction at a time.
REQ-028 When new requests arrive during ADDR or DATA, the block SHALL ignore them until IDLE. A master that deasserts m_arvalid while in ADDR is a protocol violation and its behaviour is undefined.
REQ-029 Outputs are functions of the state plus inputs only. No output depends on a master that is not granted.

Reset
REQ-030 While rst is high at a clk edge: state=IDLE, rr_ptr=0, grant_idx=0, tmo_cnt=0, late_pending=0.
REQ-031 After reset: m_arready=0, m_rvalid=0, m_rdata=0, m_rresp=0, s_arvalid=0, s_araddr=0, busy=0, s_rready=1.
REQ-032 Reset mid-transaction SHALL abandon the transaction without generating any response.

Verification
REQ-033 NUM_MST=2; m_arvalid=01, addr 0x8000_0000; slave gives arready at once and rdata 0x1234_5678 3 cycles later -> master0 gets rvalid, data 0x1234_5678, rresp 0; grant_idx=0; busy low the cycle after the R handshake.
REQ-034 m_arvalid=11 set in the cycle right after reset -> master0 is served first, then master1. With both held, the grants alternate 0,1,0,1 over 4 reads.
REQ-035 TIMEOUT=16; slave never asserts rvalid after the AR handshake -> exactly 16 cycles after the handshake, m_rvalid[g]=1, rresp=2'b10, rdata=0.
REQ-036 Continuation of REQ-035: a late slave beat 0xDEAD_BEEF is absorbed and not forwarded. The next read then returns the correct data, and no grant occurs before the late beat arrives.
REQ-037 m_rready[g] held low for 5 cycles while s_rvalid=1 -> s_rready=0, and m_rdata stays stable at the slave value for all 5 cycles.
REQ-038 rst pulsed for 1 cycle during DATA -> next cycle: state IDLE, busy=0, all m_rvalid=0, rr_ptr=0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter that lets NUM_MST AXI4-lite read masters
// share one slave AR/R channel, one transaction at a time, with an optional
// read-response timeout that answers SLVERR and then absorbs the late beat.
module axi_rd_arbiter #(
  parameter  int NUM_MST = 2,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 256,
  localparam int GW      = $clog2(NUM_MST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MST-1:0]        m_arvalid,
  input  logic [NUM_MST*ADDR_W-1:0] m_araddr,
  output logic [NUM_MST-1:0]        m_arready,
  output logic [NUM_MST-1:0]        m_rvalid,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [1:0]                m_rresp,
  input  logic [NUM_MST-1:0]        m_rready,
  output logic                      s_arvalid,
  output logic [ADDR_W-1:0]         s_araddr,
  input  logic                      s_arready,
  input  logic                      s_rvalid,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic [1:0]                s_rresp,
  output logic                      s_rready,
  output logic [GW-1:0]             grant_idx,
  output logic                      busy
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    r_state;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_late_pending;

  logic              w_pick_found;
  logic [GW-1:0]     w_pick_idx;
  logic [GW-1:0]     w_next_ptr;
  logic              w_sel_arvalid;
  logic              w_sel_rready;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_tmo_hit;

  // Master index base+off folded back into 0..NUM_MST-1 (off < NUM_MST).
  function automatic logic [GW-1:0] wrapIdx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_MST) s = s - NUM_MST;
    return GW'(s);
  endfunction

  assign w_next_ptr    = wrapIdx(int'(r_grant), 1);
  assign w_sel_arvalid = m_arvalid[r_grant];
  assign w_sel_rready  = m_rready[r_grant];
  assign w_sel_addr    = m_araddr[int'(r_grant)*ADDR_W +: ADDR_W];
  assign w_ar_hs       = (r_state == S_ADDR) && w_sel_arvalid && s_arready;
  assign w_r_hs        = (r_state == S_DATA) && s_rvalid && w_sel_rready;
  assign w_tmo_hit     = (TIMEOUT != 0) && (r_state == S_DATA) && !s_rvalid &&
                         (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign grant_idx     = r_grant;
  assign busy          = (r_state != S_IDLE);

  // Round-robin search: first requesting master at or after r_rr_ptr, wrapping.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (!w_pick_found && m_arvalid[wrapIdx(int'(r_rr_ptr), k)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = wrapIdx(int'(r_rr_ptr), k);
      end
    end
  end

  // Transaction sequencing, pointer rotation, timeout count and late-beat tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_grant        <= '0;
      r_tmo_cnt      <= '0;
      r_late_pending <= 1'b0;
    end else begin
      if (r_late_pending && s_rvalid && s_rready) r_late_pending <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_late_pending && w_pick_found) begin
            r_grant <= w_pick_idx;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_ar_hs) begin
            r_state   <= S_DATA;
            r_tmo_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_r_hs) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_ptr;
          end else if (w_tmo_hit) begin
            r_state <= S_ERR;
          end else if (!s_rvalid && (r_tmo_cnt != TW'(TIMEOUT))) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_ERR: begin
          if (w_sel_rready) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= w_next_ptr;
            r_late_pending <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Channel steering: only the granted master ever sees or drives anything.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b1;
    case (r_state)
      S_ADDR: begin
        s_arvalid          = w_sel_arvalid;
        s_araddr           = w_sel_addr;
        m_arready[r_grant] = s_arready;
        s_rready           = 1'b0;
      end
      S_DATA: begin
        m_rvalid[r_grant] = s_rvalid;
        m_rdata           = s_rdata;
        m_rresp           = s_rresp;
        s_rready          = w_sel_rready;
      end
      S_ERR: begin
        m_rvalid[r_grant] = 1'b1;
        m_rresp           = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed bench for axi_rd_arbiter with a transaction-level
// reference model compared against every output on every cycle.
module tb_axi_rd_arbiter;

  localparam int NUM_MST = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int GW      = $clog2(NUM_MST);

  localparam int PH_IDLE = 0;
  localparam int PH_ADDR = 1;
  localparam int PH_DATA = 2;
  localparam int PH_ERR  = 3;

  logic                      clk;
  logic                      rst;
  logic [NUM_MST-1:0]        m_arvalid;
  logic [NUM_MST*ADDR_W-1:0] m_araddr;
  logic [NUM_MST-1:0]        m_arready;
  logic [NUM_MST-1:0]        m_rvalid;
  logic [DATA_W-1:0]         m_rdata;
  logic [1:0]                m_rresp;
  logic [NUM_MST-1:0]        m_rready;
  logic                      s_arvalid;
  logic [ADDR_W-1:0]         s_araddr;
  logic                      s_arready;
  logic                      s_rvalid;
  logic [DATA_W-1:0]         s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rready;
  logic [GW-1:0]             grant_idx;
  logic                      busy;

  int testsRun    = 0;
  int testsFailed = 0;

  axi_rd_arbiter #(
    .NUM_MST(NUM_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .grant_idx(grant_idx), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] arv, input logic arr, input logic rv,
                               input logic [31:0] rd, input logic [1:0] mrr);
    m_arvalid = arv;
    s_arready = arr;
    s_rvalid  = rv;
    s_rdata   = rd;
    s_rresp   = 2'b00;
    m_rready  = mrr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Leaves the caller at the negedge of the cycle where the AR handshake is seen.
  task automatic waitArHandshake(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      settle();
      if (s_arvalid && s_arready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checkOutput(name, 64'(ok), 64'(1'b1));
  endtask

  // Reference model: tracks where the current transaction is and derives every
  // output from that plus the live inputs; advances once per cycle.
  int  mPhase, mGrant, mPtr, mSilent;
  bit  mLate, mValid;
  logic [NUM_MST-1:0] eArready, eRvalid;
  logic               eSArvalid, eSRready;
  logic [ADDR_W-1:0]  eSAraddr;
  logic [DATA_W-1:0]  eRdata;
  logic [1:0]         eRresp;

  initial begin
    mValid = 1'b0; mPhase = PH_IDLE; mGrant = 0; mPtr = 0; mSilent = 0; mLate = 1'b0;
  end

  // Per-cycle comparison of every DUT output against the model, then model advance.
  always @(negedge clk) begin
    if (mValid) begin
      eArready = '0; eRvalid = '0; eSArvalid = 1'b0; eSAraddr = '0;
      eRdata = '0; eRresp = 2'b00; eSRready = 1'b1;
      if (mPhase == PH_ADDR) begin
        eSArvalid        = m_arvalid[mGrant];
        eSAraddr         = m_araddr[mGrant*ADDR_W +: ADDR_W];
        eArready[mGrant] = s_arready;
        eSRready         = 1'b0;
      end else if (mPhase == PH_DATA) begin
        eRvalid[mGrant] = s_rvalid;
        eRdata          = s_rdata;
        eRresp          = s_rresp;
        eSRready        = m_rready[mGrant];
      end else if (mPhase == PH_ERR) begin
        eRvalid[mGrant] = 1'b1;
        eRresp          = 2'b10;
      end
      checkOutput("model m_arready", 64'(m_arready), 64'(eArready));
      checkOutput("model m_rvalid", 64'(m_rvalid), 64'(eRvalid));
      checkOutput("model m_rdata", 64'(m_rdata), 64'(eRdata));
      checkOutput("model m_rresp", 64'(m_rresp), 64'(eRresp));
      checkOutput("model s_arvalid", 64'(s_arvalid), 64'(eSArvalid));
      checkOutput("model s_araddr", 64'(s_araddr), 64'(eSAraddr));
      checkOutput("model s_rready", 64'(s_rready), 64'(eSRready));
      checkOutput("model busy", 64'(busy), 64'(mPhase != PH_IDLE));
      checkOutput("model grant_idx", 64'(grant_idx), 64'(mGrant));
    end
    if (rst) begin
      mValid = 1'b1; mPhase = PH_IDLE; mGrant = 0; mPtr = 0; mSilent = 0; mLate = 1'b0;
    end else if (mValid) begin
      if (mPhase == PH_IDLE) begin
        if (mLate) begin
          if (s_rvalid) mLate = 1'b0;
        end else if (m_arvalid != '0) begin
          for (int k = NUM_MST - 1; k >= 0; k--)
            if (m_arvalid[(mPtr + k) % NUM_MST]) mGrant = (mPtr + k) % NUM_MST;
          mPhase = PH_ADDR;
        end
      end else if (mPhase == PH_ADDR) begin
        if (m_arvalid[mGrant] && s_arready) begin
          mPhase  = PH_DATA;
          mSilent = 0;
        end
      end else if (mPhase == PH_DATA) begin
        if (s_rvalid && m_rready[mGrant]) begin
          mPhase = PH_IDLE;
          mPtr   = (mGrant + 1) % NUM_MST;
        end else if (!s_rvalid) begin
          mSilent++;
          if (mSilent == TIMEOUT) mPhase = PH_ERR;
        end
      end else begin
        if (m_rready[mGrant]) begin
          mPhase = PH_IDLE;
          mPtr   = (mGrant + 1) % NUM_MST;
          mLate  = 1'b1;
        end
      end
    end
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    logic [3:0] grantSeq;
    m_araddr = '0;
    s_rresp  = 2'b00;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    settle();
    checkOutput("reset busy", 64'(busy), 64'(1'b0));
    checkOutput("reset s_rready", 64'(s_rready), 64'(1'b1));
    checkOutput("reset m_rvalid", 64'(m_rvalid), 64'(2'b00));
    checkOutput("reset m_arready", 64'(m_arready), 64'(2'b00));
    checkOutput("reset s_arvalid", 64'(s_arvalid), 64'(1'b0));
    checkOutput("reset s_araddr", 64'(s_araddr), 64'(32'h0));
    checkOutput("reset m_rdata", 64'(m_rdata), 64'(32'h0));
    checkOutput("reset grant_idx", 64'(grant_idx), 64'(1'b0));

    // Single read from master 0, slave answers three cycles after the AR handshake.
    tick();
    m_araddr = {32'h0000_0000, 32'h8000_0000};
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    settle();
    checkOutput("basic no same-cycle s_arvalid", 64'(s_arvalid), 64'(1'b0));
    tick();
    settle();
    checkOutput("basic s_arvalid", 64'(s_arvalid), 64'(1'b1));
    checkOutput("basic s_araddr", 64'(s_araddr), 64'(32'h8000_0000));
    checkOutput("basic m_arready", 64'(m_arready), 64'(2'b01));
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b01);
    tick();
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h1234_5678, 2'b01);
    settle();
    checkOutput("basic m_rvalid", 64'(m_rvalid), 64'(2'b01));
    checkOutput("basic m_rdata", 64'(m_rdata), 64'(32'h1234_5678));
    checkOutput("basic m_rresp", 64'(m_rresp), 64'(2'b00));
    checkOutput("basic grant_idx", 64'(grant_idx), 64'(1'b0));
    checkOutput("basic busy in data", 64'(busy), 64'(1'b1));
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b01);
    settle();
    checkOutput("basic busy after R", 64'(busy), 64'(1'b0));

    // Both masters request from the first cycle after reset: grants alternate.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_araddr = {32'h2000_0010, 32'h1000_0020};
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    grantSeq = 4'b1010;
    for (int r = 0; r < 4; r++) begin
      waitArHandshake($sformatf("rr handshake %0d", r));
      checkOutput($sformatf("rr grant %0d", r), 64'(grant_idx), 64'(grantSeq[r]));
      checkOutput($sformatf("rr s_araddr %0d", r), 64'(s_araddr),
                  grantSeq[r] ? 64'h2000_0010 : 64'h1000_0020);
      tick();
      applyStimulus((r == 3) ? 2'b00 : 2'b11, 1'b1, 1'b1, 32'hA000_0000 + 32'(r), 2'b11);
      settle();
      checkOutput($sformatf("rr m_rvalid %0d", r), 64'(m_rvalid), grantSeq[r] ? 64'h2 : 64'h1);
      checkOutput($sformatf("rr m_rdata %0d", r), 64'(m_rdata), 64'(32'hA000_0000 + 32'(r)));
      tick();
      applyStimulus((r == 3) ? 2'b00 : 2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    end

    // Slave never answers: SLVERR 16 edges after the edge completing the AR handshake.
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b00);
    waitArHandshake("tmo handshake");
    checkOutput("tmo grant", 64'(grant_idx), 64'(1'b0));
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    for (int n = 1; n <= 16; n++) begin
      settle();
      checkOutput($sformatf("tmo quiet cycle %0d", n), 64'(m_rvalid), 64'(2'b00));
      tick();
    end
    settle();
    checkOutput("tmo m_rvalid", 64'(m_rvalid), 64'(2'b01));
    checkOutput("tmo m_rresp", 64'(m_rresp), 64'(2'b10));
    checkOutput("tmo m_rdata", 64'(m_rdata), 64'(32'h0));
    checkOutput("tmo busy", 64'(busy), 64'(1'b1));

    // Accept the error, then master 1 asks while the late beat is still owed.
    tick();
    m_araddr = {32'h3000_0040, 32'h0000_0000};
    applyStimulus(2'b10, 1'b0, 1'b0, 32'h0, 2'b01);
    tick();
    applyStimulus(2'b10, 1'b0, 1'b0, 32'h0, 2'b00);
    for (int n = 0; n < 4; n++) begin
      settle();
      checkOutput($sformatf("late no grant %0d", n), 64'(busy), 64'(1'b0));
      tick();
    end
    applyStimulus(2'b10, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b00);
    settle();
    checkOutput("late beat m_rvalid", 64'(m_rvalid), 64'(2'b00));
    checkOutput("late beat m_rdata", 64'(m_rdata), 64'(32'h0));
    checkOutput("late beat s_rready", 64'(s_rready), 64'(1'b1));
    tick();
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0, 2'b00);
    settle();
    checkOutput("late absorbed idle", 64'(busy), 64'(1'b0));
    tick();
    waitArHandshake("after late handshake");
    checkOutput("after late grant", 64'(grant_idx), 64'(1'b1));
    checkOutput("after late s_araddr", 64'(s_araddr), 64'(32'h3000_0040));

    // Master 1 stalls its R channel for five cycles while the slave holds data.
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h55AA_0F0F, 2'b00);
    for (int n = 0; n < 5; n++) begin
      settle();
      checkOutput($sformatf("stall s_rready %0d", n), 64'(s_rready), 64'(1'b0));
      checkOutput($sformatf("stall m_rdata %0d", n), 64'(m_rdata), 64'(32'h55AA_0F0F));
      checkOutput($sformatf("stall m_rvalid %0d", n), 64'(m_rvalid), 64'(2'b10));
      tick();
    end
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h55AA_0F0F, 2'b10);
    settle();
    checkOutput("stall release s_rready", 64'(s_rready), 64'(1'b1));
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    settle();
    checkOutput("stall done busy", 64'(busy), 64'(1'b0));

    // Move the pointer to 1, start another read and reset it mid-DATA.
    tick();
    m_araddr = {32'h0000_0000, 32'h4000_0000};
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    waitArHandshake("ptr move handshake");
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_0E01, 2'b01);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    waitArHandshake("abort handshake");
    checkOutput("abort grant", 64'(grant_idx), 64'(1'b0));
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b01);
    settle();
    checkOutput("abort busy before reset", 64'(busy), 64'(1'b1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checkOutput("abort busy after reset", 64'(busy), 64'(1'b0));
    checkOutput("abort m_rvalid after reset", 64'(m_rvalid), 64'(2'b00));
    checkOutput("abort grant after reset", 64'(grant_idx), 64'(1'b0));
    tick();
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b01);
    waitArHandshake("ptr reset handshake");
    checkOutput("ptr reset grant", 64'(grant_idx), 64'(1'b0));
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_0E02, 2'b01);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
